// File: rtl/ifft_pkg.sv
// Shared types and elaboration-time helpers for the streaming radix-2 IFFT.
//   cplx_t       : packed complex sample (re, im) at the default component width
//   fsm_state_t  : LOAD / COMPUTE / UNLOAD
//   bitrev()     : reverse the low log2n bits of an index
//   twiddle_rom(): {re, im} of exp(+j*2*pi*k/n) in Q1.(tw_width-1), rounded to nearest
package ifft_pkg;

    localparam int unsigned CPLX_WIDTH = 16;
    localparam int unsigned MAX_LOG2N  = 10;

    // pi and 1.0 in Q30, used by the integer sine/cosine series below
    localparam longint PI_Q30  = 64'sd3373259426;
    localparam longint ONE_Q30 = 64'sd1073741824;

    typedef struct packed {
        logic signed [CPLX_WIDTH-1:0] re;
        logic signed [CPLX_WIDTH-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        UNLOAD  = 2'd2
    } fsm_state_t;

    function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] idx,
                                                    input int unsigned          log2n);
        logic [MAX_LOG2N-1:0] r;
        logic [MAX_LOG2N-1:0] v;
        r = '0;
        v = idx;
        for (int unsigned b = 0; b < log2n; b++) begin
            r = {r[MAX_LOG2N-2:0], v[0]};
            v = v >> 1;
        end
        return r;
    endfunction

    // Integer Taylor series keeps the ROM generation free of real arithmetic.
    // Angles in [0, pi) are folded to [0, pi/2] before the series.
    function automatic logic [63:0] twiddle_rom(input int unsigned n,
                                                input int unsigned tw_width,
                                                input int unsigned k);
        longint ang;
        longint x;
        longint x2;
        longint term;
        longint c;
        longint s;
        longint half;
        longint qr;
        longint qi;
        longint maxv;
        bit     flip;
        ang  = (PI_Q30 * 2 * longint'(k)) / longint'(n);
        flip = ang > (PI_Q30 >>> 1);
        x    = flip ? (PI_Q30 - ang) : ang;
        x2   = (x * x) >>> 30;
        c    = 0;
        term = ONE_Q30;
        for (int t = 0; t < 10; t++) begin
            c    = c + term;
            term = -(((term * x2) >>> 30) / longint'((2*t + 1) * (2*t + 2)));
        end
        s    = 0;
        term = x;
        for (int t = 0; t < 10; t++) begin
            s    = s + term;
            term = -(((term * x2) >>> 30) / longint'((2*t + 2) * (2*t + 3)));
        end
        if (flip) c = -c;
        half = longint'(1) <<< (30 - tw_width);
        qr   = (c + half) >>> (31 - tw_width);
        qi   = (s + half) >>> (31 - tw_width);
        maxv = (longint'(1) <<< (tw_width - 1)) - 1;
        if (qr > maxv)      qr = maxv;
        if (qi > maxv)      qi = maxv;
        if (qr < -maxv - 1) qr = -maxv - 1;
        if (qi < -maxv - 1) qi = -maxv - 1;
        return {32'(qr), 32'(qi)};
    endfunction

endpackage

// File: rtl/ifft_r2_butterfly.sv
// Combinational radix-2 DIT butterfly with /2 scaling and saturation.
//   a, b : input pair (a = upper, b = lower leg)
//   w    : twiddle applied to b, Q1.(TW_WIDTH-1)
//   x_c  : sat((a + b*w) / 2),  y_c : sat((a - b*w) / 2)
// Build option IFFT_ROUND_EN: round half-up on the twiddle product and on the /2;
// otherwise both are plain arithmetic-shift truncation.
module ifft_r2_butterfly #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned TW_WIDTH   = 16
) (
    input  logic signed [DATA_WIDTH-1:0] a_re,
    input  logic signed [DATA_WIDTH-1:0] a_im,
    input  logic signed [DATA_WIDTH-1:0] b_re,
    input  logic signed [DATA_WIDTH-1:0] b_im,
    input  logic signed [TW_WIDTH-1:0]   w_re,
    input  logic signed [TW_WIDTH-1:0]   w_im,
    output logic signed [DATA_WIDTH-1:0] x_re_c,
    output logic signed [DATA_WIDTH-1:0] x_im_c,
    output logic signed [DATA_WIDTH-1:0] y_re_c,
    output logic signed [DATA_WIDTH-1:0] y_im_c
);

    localparam int unsigned PW = DATA_WIDTH + TW_WIDTH + 1;
    localparam int unsigned SW = DATA_WIDTH + 2;
    localparam logic signed [SW-1:0] SMAX = SW'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] SMIN = -SMAX - SW'(1);

`ifdef IFFT_ROUND_EN
    localparam logic signed [PW-1:0] PRND = PW'(1) << (TW_WIDTH - 2);
    localparam logic signed [SW-1:0] SRND = SW'(1);
`else
    localparam logic signed [PW-1:0] PRND = '0;
    localparam logic signed [SW-1:0] SRND = '0;
`endif

    logic signed [PW-1:0] p_re;
    logic signed [PW-1:0] p_im;
    logic signed [SW-1:0] t_re;
    logic signed [SW-1:0] t_im;
    logic signed [SW-1:0] s_re;
    logic signed [SW-1:0] s_im;
    logic signed [SW-1:0] d_re;
    logic signed [SW-1:0] d_im;

    function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [SW-1:0] v);
        if (v > SMAX) return DATA_WIDTH'(SMAX);
        if (v < SMIN) return DATA_WIDTH'(SMIN);
        return DATA_WIDTH'(v);
    endfunction

    // Full-precision product, then back to data scale; |b*w| < 2^(DATA_WIDTH+0.5) fits SW.
    always_comb begin
        p_re = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im) + PRND;
        p_im = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re) + PRND;
        t_re = SW'(p_re >>> (TW_WIDTH - 1));
        t_im = SW'(p_im >>> (TW_WIDTH - 1));
        s_re = (SW'(a_re) + t_re + SRND) >>> 1;
        s_im = (SW'(a_im) + t_im + SRND) >>> 1;
        d_re = (SW'(a_re) - t_re + SRND) >>> 1;
        d_im = (SW'(a_im) - t_im + SRND) >>> 1;
        x_re_c = sat(s_re);
        x_im_c = sat(s_im);
        y_re_c = sat(d_re);
        y_im_c = sat(d_im);
    end

endmodule

// File: rtl/ifft_radix2_stream.sv
// Streaming in-place radix-2 DIT IFFT with 1/N scaling (/2 per stage).
// One frame of N bins is loaded in bit-reversed order, transformed with a single
// time-shared butterfly (LOG2N*N/2 cycles), then unloaded in natural order.
// Ports:
//   clk, reset (async, active-high)
//   in_valid/in_ready/in_re/in_im      : bin input, order 0..N-1
//   out_valid/out_ready/out_re/out_im  : time-sample output, order 0..N-1
//   out_last                           : marks sample N-1
//   busy                               : high in COMPUTE or UNLOAD
// Build option IFFT_ROUND_EN selects half-up rounding inside the butterfly.
module ifft_radix2_stream
    import ifft_pkg::*;
#(
    parameter int unsigned  N          = 64,
    parameter int unsigned  DATA_WIDTH = 16,
    parameter int unsigned  TW_WIDTH   = 16,
    localparam int unsigned LOG2N      = $clog2(N)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_re,
    input  logic signed [DATA_WIDTH-1:0] in_im,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_re,
    output logic signed [DATA_WIDTH-1:0] out_im,
    output logic                         out_last,
    output logic                         busy
);

    localparam int unsigned JW  = LOG2N - 1;
    localparam int unsigned STW = $clog2(LOG2N);

    fsm_state_t          state;
    logic [LOG2N-1:0]    idx;
    logic [JW-1:0]       j;
    logic [STW-1:0]      stage;

    logic signed [DATA_WIDTH-1:0] mem_re [N];
    logic signed [DATA_WIDTH-1:0] mem_im [N];
    logic signed [TW_WIDTH-1:0]   rom_re [N/2];
    logic signed [TW_WIDTH-1:0]   rom_im [N/2];

    logic [LOG2N-1:0]    nxt_idx;
    logic [LOG2N-1:0]    load_addr;
    logic [LOG2N-1:0]    jx;
    logic [LOG2N-1:0]    span_m;
    logic [LOG2N-1:0]    bf_i;
    logic [LOG2N-1:0]    bf_p;
    logic [STW-1:0]      tw_shift;
    logic [JW-1:0]       tw_idx;
    logic                load_we;

    logic signed [DATA_WIDTH-1:0] x_re;
    logic signed [DATA_WIDTH-1:0] x_im;
    logic signed [DATA_WIDTH-1:0] y_re;
    logic signed [DATA_WIDTH-1:0] y_im;

    // Twiddle ROM: exp(+j*2*pi*k/N), k = 0..N/2-1, fixed at elaboration.
    for (genvar g = 0; g < N/2; g++) begin : g_rom
        localparam logic [63:0] ENTRY = twiddle_rom(N, TW_WIDTH, g);
        assign rom_re[g] = TW_WIDTH'(ENTRY[63:32]);
        assign rom_im[g] = TW_WIDTH'(ENTRY[31:0]);
    end

    // Butterfly addressing: i = (j/span)*2*span + j%span, p = i + span,
    // twiddle index = (j%span) * N/(2*span).
    always_comb begin
        nxt_idx   = idx + LOG2N'(1);
        load_addr = LOG2N'(bitrev(MAX_LOG2N'(idx), LOG2N));
        load_we   = (state == LOAD) && in_valid && in_ready;
        jx        = LOG2N'(j);
        span_m    = (LOG2N'(1) << stage) - LOG2N'(1);
        bf_i      = (((jx >> stage) << stage) << 1) | (jx & span_m);
        bf_p      = bf_i | (LOG2N'(1) << stage);
        tw_shift  = STW'(LOG2N - 1) - stage;
        tw_idx    = JW'((jx & span_m) << tw_shift);
    end

    ifft_r2_butterfly #(
        .DATA_WIDTH (DATA_WIDTH),
        .TW_WIDTH   (TW_WIDTH)
    ) u_bfly (
        .a_re   (mem_re[bf_i]),
        .a_im   (mem_im[bf_i]),
        .b_re   (mem_re[bf_p]),
        .b_im   (mem_im[bf_p]),
        .w_re   (rom_re[tw_idx]),
        .w_im   (rom_im[tw_idx]),
        .x_re_c (x_re),
        .x_im_c (x_im),
        .y_re_c (y_re),
        .y_im_c (y_im)
    );

    // Frame buffer: bit-reversed load writes, in-place butterfly writes; never reset.
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem_re[load_addr] <= in_re;
            mem_im[load_addr] <= in_im;
        end
        if (state == COMPUTE) begin
            mem_re[bf_i] <= x_re;
            mem_im[bf_i] <= x_im;
            mem_re[bf_p] <= y_re;
            mem_im[bf_p] <= y_im;
        end
    end

    // Control FSM with registered handshake and output signals.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= LOAD;
            idx       <= '0;
            j         <= '0;
            stage     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (load_we) begin
                        if (idx == LOG2N'(N - 1)) begin
                            state    <= COMPUTE;
                            idx      <= '0;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end else begin
                            idx <= nxt_idx;
                        end
                    end
                end
                COMPUTE: begin
                    if (j == JW'(N/2 - 1)) begin
                        j <= '0;
                        if (stage == STW'(LOG2N - 1)) begin
                            // Slot 0 was last written in stage LOG2N-1, j = 0, so it is final here.
                            stage     <= '0;
                            state     <= UNLOAD;
                            out_valid <= 1'b1;
                            out_last  <= 1'b0;
                            out_re    <= mem_re[0];
                            out_im    <= mem_im[0];
                        end else begin
                            stage <= stage + STW'(1);
                        end
                    end else begin
                        j <= j + JW'(1);
                    end
                end
                UNLOAD: begin
                    if (out_ready) begin
                        if (idx == LOG2N'(N - 1)) begin
                            state     <= LOAD;
                            idx       <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                        end else begin
                            idx      <= nxt_idx;
                            out_re   <= mem_re[nxt_idx];
                            out_im   <= mem_im[nxt_idx];
                            out_last <= (nxt_idx == LOG2N'(N - 1));
                        end
                    end
                end
                default: begin
                    state     <= LOAD;
                    idx       <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifft_radix2_stream.sv
// Self-checking bench for ifft_radix2_stream: an N=8 and an N=64 instance.
// Expected samples come from a floating-point IFFT/N model pushed into a queue
// when each frame is loaded and popped as the DUT hands samples out.
module tb_ifft_radix2_stream;
    import ifft_pkg::*;

    logic clk;
    logic reset;

    logic               in_valid8, in_ready8, out_valid8, out_ready8, out_last8, busy8;
    logic signed [15:0] in_re8, in_im8, out_re8, out_im8;
    logic               in_valid64, in_ready64, out_valid64, out_ready64, out_last64, busy64;
    logic signed [15:0] in_re64, in_im64, out_re64, out_im64;

    int    errors;
    int    checks;
    cplx_t exp_q[$];
    logic signed [15:0] xr[64];
    logic signed [15:0] xi[64];

    // truncation error grows about 1 LSB per stage; +1 covers twiddle quantisation
    localparam int TOL8  = 4;
    localparam int TOL64 = 7;

    ifft_radix2_stream #(.N(8), .DATA_WIDTH(16), .TW_WIDTH(16)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_re(in_re8), .in_im(in_im8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_re(out_re8), .out_im(out_im8),
        .out_last(out_last8), .busy(busy8)
    );

    ifft_radix2_stream #(.N(64), .DATA_WIDTH(16), .TW_WIDTH(16)) dut64 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid64), .in_ready(in_ready64), .in_re(in_re64), .in_im(in_im64),
        .out_valid(out_valid64), .out_ready(out_ready64), .out_re(out_re64), .out_im(out_im64),
        .out_last(out_last64), .busy(busy64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic signed [15:0] to_q(input real v);
        if (v > 32767.0)  return 16'sh7fff;
        if (v < -32768.0) return 16'sh8000;
        return 16'($rtoi(v >= 0.0 ? v + 0.5 : v - 0.5));
    endfunction

    function automatic bit near(input logic signed [15:0] a, input logic signed [15:0] b,
                                input int tol);
        int d;
        d = int'(a) - int'(b);
        return (d <= tol) && (d >= -tol);
    endfunction

    // x[t] = (1/n) * sum_k X[k] * exp(+j*2*pi*k*t/n)
    function automatic void push_model(input int n);
        real sr, si, ang;
        cplx_t e;
        for (int t = 0; t < n; t++) begin
            sr = 0.0;
            si = 0.0;
            for (int k = 0; k < n; k++) begin
                ang = 6.283185307179586 * real'((k * t) % n) / real'(n);
                sr = sr + real'(xr[k]) * $cos(ang) - real'(xi[k]) * $sin(ang);
                si = si + real'(xr[k]) * $sin(ang) + real'(xi[k]) * $cos(ang);
            end
            e.re = to_q(sr / real'(n));
            e.im = to_q(si / real'(n));
            exp_q.push_back(e);
        end
    endfunction

    task automatic clear_frame();
        for (int k = 0; k < 64; k++) begin
            xr[k] = '0;
            xi[k] = '0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Loads xr/xi[0..7]; leaves in_valid high with junk so COMPUTE must ignore it.
    task automatic load8(input bit push);
        bit acc;
        int cyc;
        for (int k = 0; k < 8; k++) begin
            in_valid8 = 1'b1;
            in_re8    = xr[k];
            in_im8    = xi[k];
            acc = 1'b0;
            cyc = 0;
            while (!acc && cyc < 50) begin
                acc = in_ready8;
                tick();
                cyc++;
            end
            if (!acc) begin
                errors++;
                checks++;
                $display("FAIL load8_timeout k=%0d in_ready=%0b want 1", k, in_ready8);
                return;
            end
        end
        in_re8 = 16'sh5a5a;
        in_im8 = -16'sh1234;
        checks++;
        if (in_ready8 !== 1'b0 || busy8 !== 1'b1) begin
            errors++;
            $display("FAIL load8_end in_ready=%0b busy=%0b want 0 1", in_ready8, busy8);
        end
        if (push) push_model(8);
    endtask

    task automatic unload8(input int tol, input bit stall, input string name);
        int    cyc;
        int    got;
        cplx_t e;
        cyc = 0;
        got = 0;
        while (!out_valid8 && cyc < 200) begin
            tick();
            cyc++;
        end
        in_valid8 = 1'b0;
        while (got < 8 && cyc < 600) begin
            if (out_valid8) begin
                out_ready8 = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s n=%0d extra sample (%0d,%0d) want none", name, got,
                             out_re8, out_im8);
                end else if (out_ready8) begin
                    e = exp_q.pop_front();
                    if (!near(out_re8, e.re, tol) || !near(out_im8, e.im, tol) ||
                        out_last8 !== (got == 7)) begin
                        errors++;
                        $display("FAIL %s n=%0d got (%0d,%0d) last=%0b want (%0d,%0d) last=%0b tol=%0d",
                                 name, got, out_re8, out_im8, out_last8, e.re, e.im,
                                 (got == 7), tol);
                    end
                    got++;
                end else begin
                    e = exp_q[0];
                    if (!near(out_re8, e.re, tol) || !near(out_im8, e.im, tol)) begin
                        errors++;
                        $display("FAIL %s_hold n=%0d got (%0d,%0d) want (%0d,%0d)",
                                 name, got, out_re8, out_im8, e.re, e.im);
                    end
                end
            end else if (got > 0) begin
                errors++;
                checks++;
                $display("FAIL %s_bubble n=%0d out_valid=0 want 1", name, got);
            end
            tick();
            cyc++;
        end
        out_ready8 = 1'b0;
        checks++;
        if (got != 8) begin
            errors++;
            $display("FAIL %s_count got %0d samples want 8", name, got);
        end
        checks++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL %s_end out_valid=%0b in_ready=%0b busy=%0b want 0 1 0",
                     name, out_valid8, in_ready8, busy8);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid8 = 1'b0;  in_re8 = '0;  in_im8 = '0;  out_ready8 = 1'b0;
        in_valid64 = 1'b0; in_re64 = '0; in_im64 = '0; out_ready64 = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({in_ready8, out_valid8, out_last8, busy8, out_re8, out_im8} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 16'sd0, 16'sd0}) begin
            errors++;
            $display("FAIL reset8 got rdy=%0b vld=%0b last=%0b busy=%0b re=%0d im=%0d want 1 0 0 0 0 0",
                     in_ready8, out_valid8, out_last8, busy8, out_re8, out_im8);
        end
        checks++;
        if ({in_ready64, out_valid64, out_last64, busy64, out_re64, out_im64} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 16'sd0, 16'sd0}) begin
            errors++;
            $display("FAIL reset64 got rdy=%0b vld=%0b last=%0b busy=%0b re=%0d im=%0d want 1 0 0 0 0 0",
                     in_ready64, out_valid64, out_last64, busy64, out_re64, out_im64);
        end
    endtask

    task automatic test_dc();
        clear_frame();
        xr[0] = 16'sd16384;
        load8(1'b1);
        unload8(0, 1'b0, "dc");
    endtask

    task automatic test_bin1();
        clear_frame();
        xr[1] = 16'sd8192;
        load8(1'b1);
        unload8(TOL8, 1'b0, "bin1");
    endtask

    task automatic test_zero_timing();
        int cyc;
        clear_frame();
        load8(1'b1);
        cyc = 0;
        while (!out_valid8 && cyc < 100) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc != 12) begin
            errors++;
            $display("FAIL compute_cycles got %0d want 12", cyc);
        end
        unload8(0, 1'b0, "zero");
    endtask

    task automatic test_backpressure();
        clear_frame();
        for (int k = 0; k < 8; k++) begin
            xr[k] = 16'($signed($urandom_range(0, 8000)) - 4000);
            xi[k] = 16'($signed($urandom_range(0, 8000)) - 4000);
        end
        load8(1'b1);
        unload8(TOL8, 1'b1, "stall_rand");
        clear_frame();
        xr[1] = 16'sd8192;
        load8(1'b1);
        unload8(TOL8, 1'b1, "stall_bin1");
    endtask

    task automatic test_back_to_back();
        clear_frame();
        xr[3] = -16'sd5000;
        xi[3] = 16'sd3000;
        load8(1'b1);
        unload8(TOL8, 1'b0, "b2b_a");
        clear_frame();
        xr[7] = 16'sd12000;
        xi[0] = -16'sd8000;
        load8(1'b1);
        unload8(TOL8, 1'b0, "b2b_b");
    endtask

    task automatic test_reset_mid_compute();
        clear_frame();
        xr[5] = 16'sd20000;
        load8(1'b0);
        repeat (5) tick();
        in_valid8 = 1'b0;
        checks++;
        if (busy8 !== 1'b1 || out_valid8 !== 1'b0) begin
            errors++;
            $display("FAIL mid_compute busy=%0b out_valid=%0b want 1 0", busy8, out_valid8);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL abort out_valid=%0b in_ready=%0b busy=%0b want 0 1 0",
                     out_valid8, in_ready8, busy8);
        end
        clear_frame();
        xr[0] = 16'sd16384;
        load8(1'b1);
        unload8(0, 1'b0, "after_abort");
    endtask

    task automatic test_full_scale64();
        bit    acc;
        int    cyc;
        int    got;
        cplx_t e;
        clear_frame();
        for (int k = 0; k < 64; k++) begin
            xr[k] = 16'sd32767;
            xi[k] = 16'sd32767;
        end
        for (int k = 0; k < 64; k++) begin
            in_valid64 = 1'b1;
            in_re64    = xr[k];
            in_im64    = xi[k];
            acc = 1'b0;
            cyc = 0;
            while (!acc && cyc < 50) begin
                acc = in_ready64;
                tick();
                cyc++;
            end
        end
        in_valid64 = 1'b0;
        push_model(64);
        cyc = 0;
        while (!out_valid64 && cyc < 400) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc != 192) begin
            errors++;
            $display("FAIL compute_cycles64 got %0d want 192", cyc);
        end
        got = 0;
        out_ready64 = 1'b1;
        while (got < 64 && cyc < 800) begin
            if (out_valid64 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (!near(out_re64, e.re, TOL64) || !near(out_im64, e.im, TOL64) ||
                    out_last64 !== (got == 63)) begin
                    errors++;
                    $display("FAIL full64 n=%0d got (%0d,%0d) last=%0b want (%0d,%0d) last=%0b tol=%0d",
                             got, out_re64, out_im64, out_last64, e.re, e.im, (got == 63), TOL64);
                end
                got++;
            end
            tick();
            cyc++;
        end
        out_ready64 = 1'b0;
        checks++;
        if (got != 64 || out_valid64 !== 1'b0 || in_ready64 !== 1'b1) begin
            errors++;
            $display("FAIL full64_end got %0d samples out_valid=%0b in_ready=%0b want 64 0 1",
                     got, out_valid64, in_ready64);
        end
        exp_q.delete();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_dc();
        test_bin1();
        test_zero_timing();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_compute();
        test_full_scale64();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
